// File: rtl/vector_packer_if.sv
// Stream bundle for vector_packer: byte-pair beats in, packed lane vectors out.
// The slave view belongs to the packer and the master view to its environment.
interface vector_packer_if #(
    parameter int LANES = 16,
    parameter int BW    = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [BW-1:0]                 in_pixel;
    logic [BW-1:0]                 in_weight;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*BW-1:0]           out_pixels;
    logic [LANES*BW-1:0]           out_weights;
    logic                          out_last;
    logic [$clog2(LANES+1)-1:0]    out_count;

    modport slave (
        input  in_valid, in_pixel, in_weight, in_last, out_ready,
        output in_ready, out_valid, out_pixels, out_weights, out_last, out_count
    );

    modport master (
        output in_valid, in_pixel, in_weight, in_last, out_ready,
        input  in_ready, out_valid, out_pixels, out_weights, out_last, out_count
    );
endinterface

// File: rtl/vector_packer.sv
// Packs a stream of pixel/weight byte pairs into LANES-wide vectors, lane 0 in the MSB byte.
// A completed vector is parked in the assembly registers (HOLD) while the output register is busy.
module vector_packer #(
    parameter int LANES = 16,
    parameter int BW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    vector_packer_if.slave bus
);
    localparam int VW    = LANES * BW;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W = $clog2(LANES + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] lane_q;
    logic [VW-1:0]    asm_pix_q, asm_wgt_q;
    logic [VW-1:0]    out_pix_q, out_wgt_q;
    logic [CNT_W-1:0] hold_cnt_q, out_cnt_q;
    logic             hold_last_q, out_last_q;
    logic             out_valid_q, in_ready_q;

    logic [VW-1:0]    asm_pix_d, asm_wgt_d;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept, complete, out_free;

    // Assembly contents with the current beat dropped into its lane.
    always_comb begin
        asm_pix_d = asm_pix_q;
        asm_wgt_d = asm_wgt_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == IDX_W'(k)) begin
                asm_pix_d[(LANES-k)*BW-1 -: BW] = bus.in_pixel;
                asm_wgt_d[(LANES-k)*BW-1 -: BW] = bus.in_weight;
            end
        end
    end

    assign accept   = bus.in_valid & in_ready_q;
    assign complete = accept & (bus.in_last | (lane_q == IDX_W'(LANES - 1)));
    assign out_free = ~out_valid_q | bus.out_ready;
    assign beat_cnt = CNT_W'(lane_q) + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            lane_q      <= '0;
            asm_pix_q   <= '0;
            asm_wgt_q   <= '0;
            out_pix_q   <= '0;
            out_wgt_q   <= '0;
            hold_cnt_q  <= '0;
            out_cnt_q   <= '0;
            hold_last_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // Consumed output drops unless a replacement is loaded below.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (complete && out_free) begin
                            out_pix_q   <= asm_pix_d;
                            out_wgt_q   <= asm_wgt_d;
                            out_cnt_q   <= beat_cnt;
                            out_last_q  <= bus.in_last;
                            out_valid_q <= 1'b1;
                            asm_pix_q   <= '0;
                            asm_wgt_q   <= '0;
                            lane_q      <= '0;
                        end else if (complete) begin
                            asm_pix_q   <= asm_pix_d;
                            asm_wgt_q   <= asm_wgt_d;
                            hold_cnt_q  <= beat_cnt;
                            hold_last_q <= bus.in_last;
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                        end else begin
                            asm_pix_q   <= asm_pix_d;
                            asm_wgt_q   <= asm_wgt_d;
                            lane_q      <= lane_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // out_valid is always high here, so out_ready alone frees the register.
                    if (bus.out_ready) begin
                        out_pix_q   <= asm_pix_q;
                        out_wgt_q   <= asm_wgt_q;
                        out_cnt_q   <= hold_cnt_q;
                        out_last_q  <= hold_last_q;
                        out_valid_q <= 1'b1;
                        asm_pix_q   <= '0;
                        asm_wgt_q   <= '0;
                        lane_q      <= '0;
                        state_q     <= FILL;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pixels  = out_pix_q;
    assign bus.out_weights = out_wgt_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_count   = out_cnt_q;
endmodule

// File: doc/vector_packer.md
VECTOR_PACKER -- requirements
Module: vector_packer

Interface
REQ-001 Parameter LANES, default 16, number of byte lanes per output vector.
REQ-002 Parameter BW, default 8, bits per pixel and per weight lane.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  beat offered on in_pixel/in_weight/in_last.
REQ-006 in_ready  output  1  packer accepts the beat this cycle.
REQ-007 in_pixel  input  BW  one pixel byte.
REQ-008 in_weight  input  BW  matching weight byte.
REQ-009 in_last  input  1  final beat of the current vector; unwritten lanes are padded.
REQ-010 out_valid  output  1  packed vector available.
REQ-011 out_ready  input  1  downstream dot-product stage takes the vector.
REQ-012 out_pixels  output  LANES*BW  packed pixels; lane 0 in the MSB byte [LANES*BW-1 -: BW].
REQ-013 out_weights  output  LANES*BW  packed weights, same lane order as out_pixels.
REQ-014 out_last  output  1  vector was closed by in_last.
REQ-015 out_count  output  5  number of written lanes, 1..16.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both high on a rising clk edge; no other condition accepts a beat.
REQ-017 Accepted beat k of a vector (k = 0..LANES-1) SHALL be written to lane k of the assembly pixel and weight registers.
REQ-018 A vector SHALL complete on the accepted beat with k = LANES-1, or on an accepted beat with in_last = 1, whichever occurs first.
REQ-019 Lanes not written before completion SHALL be zero in both out_pixels and out_weights.
REQ-020 State machine SHALL have two states: FILL (in_ready = 1) and HOLD (in_ready = 0, complete vector parked in assembly).
REQ-021 On completion in FILL, the vector SHALL move to the output register at the same edge if out_valid = 0 or (out_valid and out_ready); otherwise the state SHALL go to HOLD.
REQ-022 In HOLD with out_valid and out_ready, the parked vector SHALL load into the output register at that edge, the assembly registers SHALL clear, and the state SHALL return to FILL.
REQ-023 Latency SHALL be one cycle: out_valid rises on the edge that accepts the completing beat, given a free output register.
REQ-024 out_valid SHALL deassert only after out_ready is sampled high with no replacement vector loaded; out_pixels, out_weights, out_last and out_count SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-025 With out_ready held high, throughput SHALL be one beat per cycle with no bubbles at vector boundaries.
REQ-026 Lane counter SHALL wrap to 0 and the assembly registers SHALL clear whenever a vector leaves the assembly stage.
REQ-027 in_last on beat k = LANES-1 SHALL produce out_count = 16 and out_last = 1.

Reset
REQ-028 While rst_n = 0: state = FILL, lane counter = 0, assembly registers = 0, out_valid = 0, out_pixels = 0, out_weights = 0, out_last = 0, out_count = 0, in_ready = 1 after release.
REQ-029 Assertion of rst_n mid-vector SHALL discard the partial vector and any held or output vector, with no output pulse.

Verification
REQ-030 Stream: 16 beats, pixel = k+1, weight = 0x02, out_ready = 1 -> one cycle after beat 15, out_valid = 1 with out_pixels = 0x0102...0F10, out_weights = 0x0202...0202, out_count = 16, out_last = 0; downstream sum = 272.
REQ-031 Short vector: 3 beats of pixel 0xFF, weight 0x01, in_last on beat 2 -> out_pixels = 0xFFFFFF followed by 26 zero nibbles, out_count = 3, out_last = 1.
REQ-032 Backpressure: out_ready = 0, 40 beats offered -> beats 0-15 go to the output register, beats 16-31 go to HOLD, in_ready = 0 from then on; one cycle with out_ready = 1 -> second vector appears the next cycle and in_ready returns to 1.
REQ-033 Stall compliance: in_valid = 1 while in_ready = 0 -> no lane is written and the lane counter is unchanged.
REQ-034 Reset mid-operation: rst_n pulsed low after 7 beats while out_valid = 1 -> all outputs are 0 immediately; next 16 beats form a clean vector with no residue from earlier beats.
REQ-035 Back-to-back: 48 beats continuous, out_ready = 1 -> three consecutive out_valid cycles with correct contents and no in_ready deassertion.
